// File: rtl/tdt_dmi_gated_clk_ctrl.sv
// Multi-channel clock-gating controller: per-channel OFF/ON/HOLD FSM with a
// programmable hold tail, one clock gate per channel, and activity status.
module tdt_dmi_gated_clk_ctrl #(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned HOLD_W = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              module_en,
  input  logic [CH_NUM-1:0] local_en,
  input  logic [CH_NUM-1:0] external_en,
  input  logic              force_on,
  input  logic [HOLD_W-1:0] hold_cfg,
  input  logic              pad_yy_icg_scan_en,
  output logic [CH_NUM-1:0] clk_out,
  output logic [CH_NUM-1:0] ch_on,
  output logic              all_idle
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e            state_q [CH_NUM];
  state_e            state_d [CH_NUM];
  logic [HOLD_W-1:0] cnt_q   [CH_NUM];
  logic [HOLD_W-1:0] cnt_d   [CH_NUM];
  logic [CH_NUM-1:0] en_q, en_d;
  logic              all_idle_q, all_idle_d;
  logic [CH_NUM-1:0] req_c;
  logic [CH_NUM-1:0] pre_en_c;

  assign req_c = local_en | external_en | {CH_NUM{module_en | force_on}};

  // Next-state, hold counter and gate enable for every channel
  always_comb begin
    en_d = '0;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (req_c[i]) state_d[i] = ST_ON;
        end
        ST_ON: begin
          if (!req_c[i]) begin
            if (hold_cfg == '0) begin
              state_d[i] = ST_OFF;
            end else begin
              state_d[i] = ST_HOLD;
              cnt_d[i]   = hold_cfg - HOLD_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (req_c[i]) begin
            state_d[i] = ST_ON;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_OFF;
          end else begin
            cnt_d[i] = cnt_q[i] - HOLD_W'(1);
          end
        end
        default: state_d[i] = ST_OFF;
      endcase
      en_d[i] = (state_d[i] != ST_OFF);
    end
    all_idle_d = ~|en_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < int'(CH_NUM); i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      en_q       <= '0;
      all_idle_q <= 1'b1;
    end else begin
      for (int i = 0; i < int'(CH_NUM); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      en_q       <= en_d;
      all_idle_q <= all_idle_d;
    end
  end

  assign ch_on    = en_q;
  assign all_idle = all_idle_q;

  // Scan enable bypasses the FSM and goes straight into the gate
  assign pre_en_c = en_q | {CH_NUM{pad_yy_icg_scan_en}};

  for (genvar g = 0; g < int'(CH_NUM); g++) begin : g_gate
`ifdef TDT_DMI_GATED_CELL
    tdt_dmi_gated_cell u_cell (
      .clk_in      (clk_in),
      .external_en (pre_en_c[g]),
      .SE          (pad_yy_icg_scan_en),
      .clk_out     (clk_out[g])
    );
`else
    logic lat_en;
    // Latch is transparent only in the low phase, so the AND cannot glitch
    always_latch begin
      if (!clk_in) lat_en = pre_en_c[g];
    end
    assign clk_out[g] = clk_in & lat_en;
`endif
  end

endmodule

// File: tb/tb_tdt_dmi_gated_clk_ctrl.sv
// Bench for tdt_dmi_gated_clk_ctrl: directed scenarios plus random traffic,
// compared against a per-channel "remaining on-cycles" budget model.
module tb_tdt_dmi_gated_clk_ctrl;

  localparam int unsigned CH_NUM = 4;
  localparam int unsigned HOLD_W = 4;

  logic              clk;
  logic              rst;
  logic              module_en;
  logic [CH_NUM-1:0] local_en;
  logic [CH_NUM-1:0] external_en;
  logic              force_on;
  logic [HOLD_W-1:0] hold_cfg;
  logic              scan_en;
  logic [CH_NUM-1:0] clk_out;
  logic [CH_NUM-1:0] ch_on;
  logic              all_idle;

  int checks = 0;
  int errors = 0;

  // Model: on flag, and remaining on-cycles once the request has gone (-1 = still requested)
  bit                m_on   [CH_NUM];
  int                m_left [CH_NUM];
  logic [CH_NUM-1:0] m_en, m_prev_en;
  bit                warm = 0;
  int                on_cnt [CH_NUM];
  int                pulse_cnt [CH_NUM];
  int                gap_cnt;

  tdt_dmi_gated_clk_ctrl #(.CH_NUM(CH_NUM), .HOLD_W(HOLD_W)) dut (
    .clk_in             (clk),
    .rst                (rst),
    .module_en          (module_en),
    .local_en           (local_en),
    .external_en        (external_en),
    .force_on           (force_on),
    .hold_cfg           (hold_cfg),
    .pad_yy_icg_scan_en (scan_en),
    .clk_out            (clk_out),
    .ch_on              (ch_on),
    .all_idle           (all_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit req;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      req = module_en | local_en[i] | external_en[i] | force_on;
      if (rst) begin
        m_on[i] = 0; m_left[i] = 0;
      end else if (req) begin
        m_on[i] = 1; m_left[i] = -1;
      end else if (m_on[i]) begin
        if (m_left[i] < 0) m_left[i] = int'(hold_cfg);
        if (m_left[i] == 0) m_on[i] = 0;
        else m_left[i] = m_left[i] - 1;
      end
      m_en[i] = m_on[i];
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < int'(CH_NUM); i++) begin
      on_cnt[i] = 0; pulse_cnt[i] = 0;
    end
  endtask

  // One clock cycle: model update at the edge, then high- and low-phase checks
  task automatic cycle();
    logic [CH_NUM-1:0] exp_gate;
    @(posedge clk);
    m_prev_en = m_en;
    model_step();
    exp_gate = m_prev_en | {CH_NUM{scan_en}};
    #2;
    chk("ch_on", 32'(ch_on), 32'(m_en));
    chk("all_idle", 32'(all_idle), 32'(m_en == '0));
    if (warm) chk("clk_out_high", 32'(clk_out), 32'(exp_gate));
    for (int i = 0; i < int'(CH_NUM); i++) begin
      on_cnt[i]    += int'(ch_on[i]);
      pulse_cnt[i] += int'(clk_out[i]);
    end
    @(negedge clk);
    #1;
    if (warm) chk("clk_out_low", 32'(clk_out), 32'd0);
    warm = 1;
  endtask

  task automatic idle_inputs();
    module_en = 0; local_en = '0; external_en = '0; force_on = 0;
  endtask

  initial begin
    for (int i = 0; i < int'(CH_NUM); i++) begin m_on[i] = 0; m_left[i] = 0; end
    m_en = '0; m_prev_en = '0;
    rst = 1; scan_en = 0; hold_cfg = '0;
    module_en = 1; local_en = '1; external_en = '1; force_on = 1;

    // Reset with every enable active
    cycle();
    chk("rst_ch_on", 32'(ch_on), 32'd0);
    chk("rst_idle", 32'(all_idle), 32'd1);
    cycle();
    rst = 0;
    cycle();
    chk("rst_release_on", 32'(ch_on), 32'hF);
    idle_inputs();
    repeat (3) cycle();

    // Hold: single-cycle pulse on local_en[2], hold_cfg=3
    hold_cfg = 4'd3;
    local_en[2] = 1;
    clear_counts();
    cycle();
    local_en[2] = 0;
    repeat (6) cycle();
    chk("hold_on_cycles", 32'(on_cnt[2]), 32'd4);
    chk("hold_pulses", 32'(pulse_cnt[2]), 32'd4);
    chk("hold_others", 32'(on_cnt[0] + on_cnt[1] + on_cnt[3]), 32'd0);

    // Zero hold: external_en[0] for 3 cycles
    hold_cfg = '0;
    external_en[0] = 1;
    clear_counts();
    repeat (3) cycle();
    external_en[0] = 0;
    cycle();
    chk("zero_hold_idle", 32'(all_idle), 32'd1);
    repeat (2) cycle();
    chk("zero_hold_on_cycles", 32'(on_cnt[0]), 32'd3);

    // Re-request during HOLD, then a full hold
    hold_cfg = 4'd5;
    local_en[1] = 1;
    repeat (2) cycle();
    local_en[1] = 0;
    gap_cnt = 0;
    repeat (2) begin cycle(); gap_cnt += int'(!ch_on[1]); end
    local_en[1] = 1;
    repeat (2) begin cycle(); gap_cnt += int'(!ch_on[1]); end
    chk("rereq_no_gap", 32'(gap_cnt), 32'd0);
    local_en[1] = 0;
    clear_counts();
    repeat (8) cycle();
    chk("rereq_full_hold", 32'(on_cnt[1]), 32'd5);

    // Global enable pulse with hold_cfg=2
    hold_cfg = 4'd2;
    module_en = 1;
    clear_counts();
    cycle();
    module_en = 0;
    repeat (4) cycle();
    for (int i = 0; i < int'(CH_NUM); i++) chk("global_on_cycles", 32'(on_cnt[i]), 32'd3);
    force_on = 1;
    cycle();
    force_on = 0;
    repeat (4) cycle();

    // Scan enable while idle: clk_out follows clk_in, status unaffected
    scan_en = 1;
    clear_counts();
    repeat (3) cycle();
    chk("scan_pulses", 32'(pulse_cnt[3]), 32'd3);
    chk("scan_idle", 32'(all_idle), 32'd1);
    scan_en = 0;
    cycle();

    // Reset mid-HOLD with cnt=4
    hold_cfg = 4'd7;
    local_en[3] = 1;
    cycle();
    local_en[3] = 0;
    repeat (3) cycle();
    rst = 1;
    cycle();
    chk("rst_mid_hold", 32'(ch_on), 32'd0);
    rst = 0;
    cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      module_en   = ($urandom_range(0, 19) == 0);
      force_on    = ($urandom_range(0, 29) == 0);
      rst         = ($urandom_range(0, 49) == 0);
      scan_en     = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < int'(CH_NUM); i++) begin
        local_en[i]    = ($urandom_range(0, 5) == 0);
        external_en[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 3) == 0) hold_cfg = HOLD_W'($urandom_range(0, 15));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
